// File: rtl/csp_dft_scan_node.sv
// DFT scan-chain node for the CSP serial ring: bit tokens flow LS -> RS through a
// one-token output slot, via a WIDTH-bit scan register in SHIFT mode, with a shadow register loaded on UPDATE.
module csp_dft_scan_node #(
    parameter int               WIDTH      = 8,
    parameter bit               CAPTURE_EN = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                      CLK,
    input  logic                      _RESET,
    input  logic signed [1:0]         ls_d_data_i,
    output logic                      ls_d_enable_o,
    input  logic        [2:0]         ls_c_i,
    output logic signed [1:0]         rs_d_data_o,
    input  logic                      rs_d_enable_i,
    output logic        [2:0]         rs_c_o,
    input  logic        [WIDTH-1:0]   dft_in_i,
    output logic        [WIDTH-1:0]   dft_out_o,
    output logic [$clog2(WIDTH):0]    bit_cnt_o,
    output logic        [1:0]         err_o,
    input  logic                      err_clr_i
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic signed [1:0] TOK_ZERO  = 2'sb00;
    localparam logic signed [1:0] TOK_ONE   = 2'sb01;
    localparam logic signed [1:0] TOK_ILL   = 2'sb10;
    localparam logic signed [1:0] TOK_EMPTY = 2'sb11;

    // Mode encodings double as the one-hot C value forwarded downstream.
    typedef enum logic [2:0] {
        M_NONE   = 3'b000,
        M_NORMAL = 3'b001,
        M_SHIFT  = 3'b010,
        M_UPDATE = 3'b100
    } mode_t;

    mode_t              mode_q, mode_d;
    logic signed [1:0]  slot_q, slot_d;
    logic [WIDTH-1:0]   scan_q, scan_d;
    logic [WIDTH-1:0]   dft_q, dft_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;

    logic               slot_full;
    logic               rs_xfer;
    logic               ls_en;
    logic               ls_xfer;
    logic               ls_ill;
    logic               c_legal;
    mode_t              req_mode;
    logic [1:0]         err_set;
    logic [WIDTH:0]     shift_cat;

    function automatic logic is_onehot3(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    function automatic mode_t decode_mode(input logic [2:0] c, input mode_t cur);
        case (c)
            3'b001:  return M_NORMAL;
            3'b010:  return M_SHIFT;
            3'b100:  return M_UPDATE;
            default: return cur;
        endcase
    endfunction

    always_comb begin
        slot_full = (slot_q != TOK_EMPTY);
        rs_xfer   = slot_full && rs_d_enable_i;
        c_legal   = is_onehot3(ls_c_i);
        req_mode  = decode_mode(ls_c_i, mode_q);
        ls_en     = (mode_q != M_NONE) && (ls_c_i == 3'(mode_q)) && (!slot_full || rs_d_enable_i);
        ls_xfer   = ls_en && ((ls_d_data_i == TOK_ZERO) || (ls_d_data_i == TOK_ONE));
        ls_ill    = ls_en && (ls_d_data_i == TOK_ILL);
        shift_cat = {ls_d_data_i[0], scan_q};

        mode_d  = mode_q;
        slot_d  = slot_q;
        scan_d  = scan_q;
        dft_d   = dft_q;
        cnt_d   = cnt_q;
        err_set = 2'b00;

        if (rs_xfer) begin
            slot_d = TOK_EMPTY;
        end

        // A refill in the same cycle as a drain overrides the empty marker.
        if (ls_xfer) begin
            if (mode_q == M_SHIFT) begin
                slot_d = scan_q[0] ? TOK_ONE : TOK_ZERO;
                scan_d = shift_cat[WIDTH:1];
                cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end else begin
                slot_d = ls_d_data_i;
            end
        end

        if (mode_q == M_NONE) begin
            mode_d = M_NORMAL;
        end else if (c_legal && (ls_c_i != 3'(mode_q)) && !slot_full) begin
            mode_d = req_mode;
            case (req_mode)
                M_SHIFT: begin
                    cnt_d = '0;
                    if (CAPTURE_EN) begin
                        scan_d = dft_in_i;
                    end
                end
                M_UPDATE: begin
                    dft_d = scan_q;
                    if (cnt_q != '0) begin
                        err_set[1] = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // C is only meaningful once the node has left its post-reset NONE state.
        if (((mode_q != M_NONE) && !c_legal) || ls_ill) begin
            err_set[0] = 1'b1;
        end

        err_d = err_clr_i ? 2'b00 : (err_q | err_set);
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            mode_q <= M_NONE;
            slot_q <= TOK_EMPTY;
            scan_q <= '0;
            dft_q  <= RESET_VAL;
            cnt_q  <= '0;
            err_q  <= 2'b00;
        end else begin
            mode_q <= mode_d;
            slot_q <= slot_d;
            scan_q <= scan_d;
            dft_q  <= dft_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign ls_d_enable_o = ls_en;
    assign rs_d_data_o   = slot_q;
    assign rs_c_o        = mode_q;
    assign dft_out_o     = dft_q;
    assign bit_cnt_o     = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_csp_dft_scan_node.sv
// Directed bench for csp_dft_scan_node (WIDTH=8, CAPTURE_EN=1, RESET_VAL=8'h3C).
module tb_csp_dft_scan_node;

    localparam int WIDTH = 8;
    localparam logic [7:0] RV = 8'h3C;

    logic              CLK;
    logic              _RESET;
    logic signed [1:0] ls_d_data_i;
    logic              ls_d_enable_o;
    logic [2:0]        ls_c_i;
    logic signed [1:0] rs_d_data_o;
    logic              rs_d_enable_i;
    logic [2:0]        rs_c_o;
    logic [7:0]        dft_in_i;
    logic [7:0]        dft_out_o;
    logic [3:0]        bit_cnt_o;
    logic [1:0]        err_o;
    logic              err_clr_i;

    int n_chk = 0;
    int n_err = 0;

    csp_dft_scan_node #(.WIDTH(WIDTH), .CAPTURE_EN(1'b1), .RESET_VAL(RV)) dut (
        .CLK(CLK), ._RESET(_RESET),
        .ls_d_data_i(ls_d_data_i), .ls_d_enable_o(ls_d_enable_o), .ls_c_i(ls_c_i),
        .rs_d_data_o(rs_d_data_o), .rs_d_enable_i(rs_d_enable_i), .rs_c_o(rs_c_o),
        .dft_in_i(dft_in_i), .dft_out_o(dft_out_o), .bit_cnt_o(bit_cnt_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] pat;

    initial begin
        _RESET        = 1'b0;
        rs_d_enable_i = 1'b1;
        ls_d_data_i   = -2'sd1;
        ls_c_i        = 3'b001;
        dft_in_i      = 8'h00;
        err_clr_i     = 1'b0;

        // reset state
        #12;
        chk("rst_rs_data", int'(rs_d_data_o), -1);
        chk("rst_rs_c",    int'(rs_c_o), 0);
        chk("rst_ls_en",   int'(ls_d_enable_o), 0);
        chk("rst_dft_out", int'(dft_out_o), int'(RV));
        chk("rst_bit_cnt", int'(bit_cnt_o), 0);
        chk("rst_err",     int'(err_o), 0);
        _RESET = 1'b1;
        tick();
        chk("up_rs_c",    int'(rs_c_o), 1);
        chk("up_ls_en",   int'(ls_d_enable_o), 1);
        chk("up_rs_data", int'(rs_d_data_o), -1);
        chk("up_dft_out", int'(dft_out_o), int'(RV));

        // NORMAL pass-through 1,0,1
        ls_d_data_i = 2'sd1;  tick(); chk("norm_b0", int'(rs_d_data_o), 1);
        ls_d_data_i = 2'sd0;  tick(); chk("norm_b1", int'(rs_d_data_o), 0);
        ls_d_data_i = 2'sd1;  tick(); chk("norm_b2", int'(rs_d_data_o), 1);
        ls_d_data_i = -2'sd1; tick(); chk("norm_drain", int'(rs_d_data_o), -1);
        chk("norm_cnt", int'(bit_cnt_o), 0);

        // SHIFT with capture of A5, 8 zeros in
        dft_in_i = 8'hA5;
        ls_c_i   = 3'b010;
        #1 chk("sh_pend_en", int'(ls_d_enable_o), 0);
        tick();
        chk("sh_rs_c", int'(rs_c_o), 2);
        chk("sh_cnt0", int'(bit_cnt_o), 0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            ls_d_data_i = 2'sd0;
            tick();
            chk($sformatf("sh_out%0d", i), int'(rs_d_data_o), int'(pat[i]));
            chk($sformatf("sh_cnt%0d", i), int'(bit_cnt_o), (i + 1) % 8);
        end
        ls_d_data_i = -2'sd1;
        ls_c_i      = 3'b100;
        tick();
        chk("upd_drain", int'(rs_d_data_o), -1);
        chk("upd_wait_c", int'(rs_c_o), 2);
        tick();
        chk("upd_rs_c", int'(rs_c_o), 4);
        chk("upd_dft", int'(dft_out_o), 8'h00);
        chk("upd_err", int'(err_o), 0);

        // partial shift then UPDATE: capture 0F, shift in 1,1,0 -> 61
        dft_in_i = 8'h0F;
        ls_c_i   = 3'b010;
        tick();
        chk("ps_rs_c", int'(rs_c_o), 2);
        ls_d_data_i = 2'sd1; tick(); chk("ps_o0", int'(rs_d_data_o), 1);
        ls_d_data_i = 2'sd1; tick(); chk("ps_o1", int'(rs_d_data_o), 1);
        ls_d_data_i = 2'sd0; tick(); chk("ps_o2", int'(rs_d_data_o), 1);
        chk("ps_cnt", int'(bit_cnt_o), 3);
        chk("ps_dft_hold", int'(dft_out_o), 8'h00);
        ls_d_data_i = -2'sd1;
        ls_c_i      = 3'b100;
        tick();
        tick();
        chk("ps_upd_c", int'(rs_c_o), 4);
        chk("ps_dft", int'(dft_out_o), 8'h61);
        chk("ps_err", int'(err_o), 2);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("ps_clr", int'(err_o), 0);

        // backpressure: slot held full, mode request waits for drain
        rs_d_enable_i = 1'b0;
        ls_d_data_i   = 2'sd1;
        tick();
        chk("bp_fill", int'(rs_d_data_o), 1);
        chk("bp_full_en", int'(ls_d_enable_o), 0);
        ls_d_data_i = -2'sd1;
        ls_c_i      = 3'b010;
        dft_in_i    = 8'h5A;
        tick();
        chk("bp_c_hold1", int'(rs_c_o), 4);
        tick();
        chk("bp_c_hold2", int'(rs_c_o), 4);
        chk("bp_data_hold", int'(rs_d_data_o), 1);
        rs_d_enable_i = 1'b1;
        #1 chk("bp_pend_en", int'(ls_d_enable_o), 0);
        tick();
        chk("bp_drain", int'(rs_d_data_o), -1);
        chk("bp_c_drain", int'(rs_c_o), 4);
        tick();
        chk("bp_c_new", int'(rs_c_o), 2);
        chk("bp_en_new", int'(ls_d_enable_o), 1);

        // reset mid-shift, then illegal C after release
        ls_d_data_i = 2'sd1;
        tick();
        chk("rs2_pre_cnt", int'(bit_cnt_o), 1);
        _RESET = 1'b0;
        #1;
        chk("rs2_data", int'(rs_d_data_o), -1);
        chk("rs2_c", int'(rs_c_o), 0);
        chk("rs2_cnt", int'(bit_cnt_o), 0);
        chk("rs2_dft", int'(dft_out_o), int'(RV));
        chk("rs2_en", int'(ls_d_enable_o), 0);
        ls_d_data_i = -2'sd1;
        ls_c_i      = 3'b011;
        #2 _RESET = 1'b1;
        tick();
        chk("ill_c_mode1", int'(rs_c_o), 1);
        tick();
        chk("ill_c_mode2", int'(rs_c_o), 1);
        chk("ill_c_err", int'(err_o), 1);
        chk("ill_c_en", int'(ls_d_enable_o), 0);

        // illegal token: err_clr wins in the same cycle, then err[0] set
        ls_c_i      = 3'b001;
        ls_d_data_i = -2'sd2;
        err_clr_i   = 1'b1;
        tick();
        chk("tok_clr_prio", int'(err_o), 0);
        err_clr_i = 1'b0;
        tick();
        chk("tok_err", int'(err_o), 1);
        chk("tok_slot", int'(rs_d_data_o), -1);
        ls_d_data_i = -2'sd1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/csp_dft_scan_node.md
Name: csp_dft_scan_node

Overview:
- Clocked, parametrised DFT scan-chain node for the CSP DFT serial ring.
- Receives bit tokens and a one-hot mode control C from the left side (LS) and forwards them to the right side (RS).
- In SHIFT mode, tokens pass through a WIDTH-bit scan register. In UPDATE mode, the scan register is copied to a shadow register that drives local test controls.
- Successor to the fixed-width DFT stub and passthru nodes: adds real storage, capture and update.

Parameters:
WIDTH, 8, scan/shadow register length in bits (>=1)
CAPTURE_EN, 1, 1: load dft_in into the scan register on entry to SHIFT; 0: scan register retains its contents
RESET_VAL, 0, value of dft_out and the shadow register while/after reset

Ports:
CLK  in  1  rising-edge clock
_RESET  in  1  reset, asynchronous, active-low
LS.D$data  in  2 signed  input token: 0/1 = bit, -1 = empty, -2 = illegal
LS.D$enable  out  1  ready to accept an LS token
LS.C  in  3  mode request, one-hot: [0] NORMAL, [1] SHIFT, [2] UPDATE
RS.D$data  out  2 signed  output token: -1 = empty
RS.D$enable  in  1  downstream ready
RS.C  out  3  current mode, forwarded downstream
dft_in  in  WIDTH  local capture data
dft_out  out  WIDTH  shadow register (local test controls)
bit_cnt  out  clog2(WIDTH)+1  bits shifted since SHIFT entry, modulo WIDTH
err  out  2  sticky: [0] illegal token or illegal C, [1] UPDATE with partial shift
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async assert, sync to CLK on release):
  - RS.D$data = -1, RS.C = 3'b000, LS.D$enable = 0.
  - scan = 0, dft_out = RESET_VAL, bit_cnt = 0, err = 0, mode = NONE.
- First CLK edge after _RESET rises: mode = NORMAL, RS.C = 3'b001.
- Reset asserted mid-shift or mid-transfer: all state is discarded immediately. No partial update of dft_out.
- Output slot: a single register (RS.D$data).
  - RS transfer occurs at the CLK edge where RS.D$data != -1 and RS.D$enable = 1; the slot becomes -1 unless refilled in the same cycle.
- LS.D$enable (combinational) = mode != NONE && LS.C == RS.C && (slot empty || RS.D$enable).
  - Throughput: 1 token/cycle; drain and refill in the same cycle are allowed.
- LS transfer: at the CLK edge where LS.D$enable = 1 and LS.D$data is in {0,1}.
  - LS.D$data = -2 with enable high: token dropped, err[0] set, slot unchanged.
- NORMAL and UPDATE modes: accepted bit b goes straight to the slot (1-cycle latency).
- SHIFT mode, accepted bit b:
  - slot <= scan[0]
  - scan <= {b, scan[WIDTH-1:1]}
  - bit_cnt <= (bit_cnt == WIDTH-1) ? 0 : bit_cnt + 1
  - First-in bit appears on RS after WIDTH + 1 accepted tokens.
- Mode change:
  - Pending whenever LS.C != RS.C. While pending, LS.D$enable = 0.
  - Taken at the first edge where the slot is empty (after drain): mode and RS.C <= LS.C.
  - Entry to SHIFT: bit_cnt <= 0; if CAPTURE_EN, scan <= dft_in (sampled at that edge).
  - Entry to UPDATE: dft_out <= scan (same edge). If bit_cnt != 0, err[1] set. Scan is kept.
  - Entry to NORMAL: no state change.
- Illegal LS.C (not one-hot, including 000): no mode change, err[0] set while present. LS.D$enable is computed against the current mode (no deadlock).
- err_clr has priority over any set in the same cycle.
- dft_out changes only on UPDATE entry or reset.

Test Plan:
- Reset release, RS.D$enable = 1, LS idle -> first edge RS.C = 001, LS.D$enable = 1, RS.D$data = -1, dft_out = RESET_VAL.
- NORMAL mode, LS sends 1,0,1 back-to-back with RS always ready -> RS emits 1,0,1 one cycle later at 1 token/cycle; bit_cnt stays 0.
- WIDTH = 8, CAPTURE_EN = 1, dft_in = 8'hA5, enter SHIFT, send 8 zeros -> RS emits 1,0,1,0,0,1,0,1 (LSB first); bit_cnt wraps to 0; then enter UPDATE -> dft_out = 8'h00, err = 0.
- SHIFT mode, send 3 tokens, then request UPDATE -> err[1] = 1 and dft_out = partially shifted scan value; err_clr pulse -> err = 0.
- RS.D$enable held 0 with the slot full, LS.C changed to SHIFT -> LS.D$enable = 0 and RS.C unchanged until RS.D$enable rises; the mode switch follows the drain edge.
- Assert _RESET during SHIFT mid-stream, then LS.C = 3'b011 after release -> outputs return to reset values immediately; on the illegal C, err[0] = 1 and the mode stays NORMAL.
